// File: rtl/odd_even_seq_checker_pkg.sv
// ---------------------------------------------------------------------------
// odd_even_pkg
// Shared definitions for the odd/even sequence checker: FSM state encoding,
// the counter step, the mode constants and a small parity helper.
// No ports (package).
// ---------------------------------------------------------------------------
package odd_even_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int   STEP      = 2;
   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

   // True when the word's LSB belongs to the sequence selected by mode.
   function automatic logic parity_ok(input logic lsb, input logic mode);
      logic word_mode;
      word_mode = lsb ? MODE_ODD : MODE_EVEN;
      return (word_mode == mode);
   endfunction

endpackage

// File: rtl/odd_even_seq_checker_if.sv
// ---------------------------------------------------------------------------
// odd_even_seq_checker_if
// Bundles the sample stream and the checker status outputs.
//   M, Q_in, Q_valid           : sample side (driven by the master)
//   locked, expected           : lock status and next expected word
//   err_pulse/parity_err/step_err : per-sample error flags
//   err_count                  : saturating error total
// master modport: the source/observer; slave modport: the checker.
// ---------------------------------------------------------------------------
interface odd_even_seq_checker_if #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
);
   logic             M;
   logic [WIDTH-1:0] Q_in;
   logic             Q_valid;
   logic             locked;
   logic [WIDTH-1:0] expected;
   logic             err_pulse;
   logic             parity_err;
   logic             step_err;
   logic [ERR_W-1:0] err_count;

   modport master (
      output M, Q_in, Q_valid,
      input  locked, expected, err_pulse, parity_err, step_err, err_count
   );

   modport slave (
      input  M, Q_in, Q_valid,
      output locked, expected, err_pulse, parity_err, step_err, err_count
   );
endinterface

// File: rtl/odd_even_seq_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Registered up-counter with synchronous clear that sticks at all-ones.
//   clk_i   : rising-edge clock
//   clr_i   : synchronous active-high clear (wins over inc_i)
//   inc_i   : add one this cycle
//   count_o : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int ERR_W = 8
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [ERR_W-1:0] count_o
);

   logic [ERR_W-1:0] count_q;
   logic [ERR_W-1:0] count_d;

   // Next count: increment unless already at the ceiling.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {ERR_W{1'b1}})) begin
         count_d = count_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         count_q <= {ERR_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/odd_even_seq_checker.sv
// ---------------------------------------------------------------------------
// odd_even_seq_checker
// Receive-side monitor for an odd/even +2 counter stream. Hunts for a word
// of the right parity, tracks until LOCK_COUNT consecutive good words, then
// flags every bad word while locked (parity or step), counts errors, and
// drops lock after LOSS_COUNT consecutive bad words. All outputs registered.
//   Clock : rising-edge clock
//   Clear : synchronous active-high reset, beats every other input
//   bus   : odd_even_seq_checker_if.slave (samples in, status out)
// ---------------------------------------------------------------------------
module odd_even_seq_checker
   import odd_even_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 3,
   parameter int LOSS_COUNT = 2,
   parameter int ERR_W      = 8
) (
   input  logic                  Clock,
   input  logic                  Clear,
   odd_even_seq_checker_if.slave bus
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);
   localparam logic [GW-1:0]    LOCK_CNT_C = GW'(LOCK_COUNT);
   localparam logic [LW-1:0]    LOSS_CNT_C = LW'(LOSS_COUNT);
   localparam logic [WIDTH-1:0] STEP_C     = WIDTH'(STEP);

   state_e           state_q;
   logic             mode_q;
   logic [WIDTH-1:0] expected_q;
   logic [GW-1:0]    good_run_q;
   logic [LW-1:0]    miss_run_q;
   logic             locked_q;
   logic             err_pulse_q;
   logic             parity_err_q;
   logic             step_err_q;
   logic [ERR_W-1:0] err_count_s;

   logic             mode_chg_s;
   logic             par_ok_s;
   logic             match_s;
   logic             err_inc_s;
   logic [WIDTH-1:0] seed_d;
   logic [WIDTH-1:0] fly_d;
   logic [GW-1:0]    good_inc_d;
   logic [LW-1:0]    miss_inc_d;

   // Decode of the current sample against the tracked state.
   always_comb begin
      mode_chg_s = (bus.M != mode_q);
      par_ok_s   = parity_ok(bus.Q_in[0], mode_q);
      match_s    = (bus.Q_in == expected_q);
      seed_d     = bus.Q_in + STEP_C;
      fly_d      = expected_q + STEP_C;
      good_inc_d = good_run_q + GW'(1);
      miss_inc_d = miss_run_q + LW'(1);
      // A mode change discards the sample, so it can never count as an error.
      if (bus.Q_valid && !mode_chg_s && (state_q == ST_LOCKED) && !match_s) begin
         err_inc_s = 1'b1;
      end else begin
         err_inc_s = 1'b0;
      end
   end

   // Hunt/track/lock FSM with its registered outputs.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q      <= ST_HUNT;
         mode_q       <= bus.M;
         expected_q   <= {WIDTH{1'b0}};
         good_run_q   <= {GW{1'b0}};
         miss_run_q   <= {LW{1'b0}};
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         parity_err_q <= 1'b0;
         step_err_q   <= 1'b0;
      end else begin
         err_pulse_q  <= 1'b0;
         parity_err_q <= 1'b0;
         step_err_q   <= 1'b0;
         if (mode_chg_s) begin
            mode_q     <= bus.M;
            state_q    <= ST_HUNT;
            locked_q   <= 1'b0;
            good_run_q <= {GW{1'b0}};
            miss_run_q <= {LW{1'b0}};
         end else if (bus.Q_valid) begin
            case (state_q)
               ST_HUNT: begin
                  if (par_ok_s) begin
                     expected_q <= seed_d;
                     good_run_q <= GW'(1);
                     if (LOCK_COUNT == 1) begin
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        miss_run_q <= {LW{1'b0}};
                     end else begin
                        state_q <= ST_TRACK;
                     end
                  end
               end
               ST_TRACK: begin
                  if (match_s) begin
                     good_run_q <= good_inc_d;
                     expected_q <= fly_d;
                     if (good_inc_d == LOCK_CNT_C) begin
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        miss_run_q <= {LW{1'b0}};
                     end
                  end else if (par_ok_s) begin
                     // Right parity, wrong value: restart the run from this word.
                     expected_q <= seed_d;
                     good_run_q <= GW'(1);
                  end else begin
                     state_q    <= ST_HUNT;
                     good_run_q <= {GW{1'b0}};
                  end
               end
               ST_LOCKED: begin
                  // Flywheel: advance even on a miss, assuming the sender did.
                  expected_q <= fly_d;
                  if (match_s) begin
                     miss_run_q <= {LW{1'b0}};
                  end else begin
                     err_pulse_q  <= 1'b1;
                     parity_err_q <= ~par_ok_s;
                     step_err_q   <= par_ok_s;
                     miss_run_q   <= miss_inc_d;
                     if (miss_inc_d == LOSS_CNT_C) begin
                        state_q    <= ST_HUNT;
                        locked_q   <= 1'b0;
                        miss_run_q <= {LW{1'b0}};
                        good_run_q <= {GW{1'b0}};
                     end
                  end
               end
               default: begin
                  state_q    <= ST_HUNT;
                  locked_q   <= 1'b0;
                  good_run_q <= {GW{1'b0}};
                  miss_run_q <= {LW{1'b0}};
               end
            endcase
         end
      end
   end

   sat_counter #(
      .ERR_W (ERR_W)
   ) u_err_cnt (
      .clk_i   (Clock),
      .clr_i   (Clear),
      .inc_i   (err_inc_s),
      .count_o (err_count_s)
   );

   assign bus.locked     = locked_q;
   assign bus.expected   = expected_q;
   assign bus.err_pulse  = err_pulse_q;
   assign bus.parity_err = parity_err_q;
   assign bus.step_err   = step_err_q;
   assign bus.err_count  = err_count_s;

endmodule

// File: tb/tb_odd_even_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_odd_even_seq_checker
// Directed vectors with hand-computed responses. The driver pushes each
// expected response, tagged with the cycle it must appear in, into a queue;
// a negedge monitor pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_odd_even_seq_checker;

   typedef struct {
      int         due;
      logic       lk;
      logic [3:0] ex;
      logic       ce;
      logic       pu;
      logic       pe;
      logic       se;
      logic [7:0] cnt;
   } exp_t;

   logic clk;
   logic clr;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sbq[$];
   exp_t mon_e;

   odd_even_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();

   odd_even_seq_checker #(
      .WIDTH      (4),
      .LOCK_COUNT (3),
      .LOSS_COUNT (2),
      .ERR_W      (8)
   ) dut (
      .Clock (clk),
      .Clear (clr),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: compare every response that is due this cycle.
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         mon_e = sbq.pop_front();
         chk("locked",     {7'd0, bus.locked},     {7'd0, mon_e.lk});
         if (mon_e.ce) chk("expected", {4'd0, bus.expected}, {4'd0, mon_e.ex});
         chk("err_pulse",  {7'd0, bus.err_pulse},  {7'd0, mon_e.pu});
         chk("parity_err", {7'd0, bus.parity_err}, {7'd0, mon_e.pe});
         chk("step_err",   {7'd0, bus.step_err},   {7'd0, mon_e.se});
         chk("err_count",  bus.err_count,          mon_e.cnt);
      end
   end

   // Apply one cycle of inputs and queue the response due after the next edge.
   task automatic drive(input logic c, input logic m, input logic [3:0] q, input logic v,
                        input logic lk, input logic [3:0] ex, input logic ce,
                        input logic pu, input logic pe, input logic se, input logic [7:0] cnt);
      exp_t e;
      @(posedge clk);
      #1;
      clr         = c;
      bus.M       = m;
      bus.Q_in    = q;
      bus.Q_valid = v;
      e.due = cyc + 1;
      e.lk  = lk;
      e.ex  = ex;
      e.ce  = ce;
      e.pu  = pu;
      e.pe  = pe;
      e.se  = se;
      e.cnt = cnt;
      sbq.push_back(e);
   endtask

   initial begin
      logic [3:0] e4;
      logic [7:0] sat;
      checks      = 0;
      errors      = 0;
      clr         = 1'b1;
      bus.M       = 1'b0;
      bus.Q_in    = 4'd0;
      bus.Q_valid = 1'b0;

      // 1: clear with random data, then release
      //    c  m  q                      v                      lk ex ce pu pe se cnt
      drive(1, 0, 4'($urandom_range(0,15)), 1'($urandom_range(0,1)), 0, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 4'($urandom_range(0,15)), 1'($urandom_range(0,1)), 0, 0, 1, 0, 0, 0, 0);
      drive(0, 0, 4'd7,  0,                 0, 0, 1, 0, 0, 0, 0);

      // 2: even lock on 0,2,4 and wrap 14->0
      drive(0, 0, 4'd0,  1, 0, 4'd2,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd2,  1, 0, 4'd4,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd4,  1, 1, 4'd6,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd6,  1, 1, 4'd8,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd8,  1, 1, 4'd10, 1, 0, 0, 0, 0);
      drive(0, 0, 4'd10, 1, 1, 4'd12, 1, 0, 0, 0, 0);
      drive(0, 0, 4'd12, 1, 1, 4'd14, 1, 0, 0, 0, 0);
      drive(0, 0, 4'd14, 1, 1, 4'd0,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd0,  1, 1, 4'd2,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd2,  1, 1, 4'd4,  1, 0, 0, 0, 0);

      // 3: switch to odd, lock on 11,13,15 and wrap 15->1
      drive(0, 1, 4'd0,  0, 0, 4'd0,  0, 0, 0, 0, 0);
      drive(0, 1, 4'd11, 1, 0, 4'd13, 1, 0, 0, 0, 0);
      drive(0, 1, 4'd13, 1, 0, 4'd15, 1, 0, 0, 0, 0);
      drive(0, 1, 4'd15, 1, 1, 4'd1,  1, 0, 0, 0, 0);
      drive(0, 1, 4'd1,  1, 1, 4'd3,  1, 0, 0, 0, 0);

      // 4: clear mid-lock, even lock, single parity error then recovery
      drive(1, 0, 4'd5,  1, 0, 4'd0,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd0,  1, 0, 4'd2,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd2,  1, 0, 4'd4,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd4,  1, 1, 4'd6,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd9,  1, 1, 4'd8,  1, 1, 1, 0, 1);
      drive(0, 0, 4'd8,  1, 1, 4'd10, 1, 0, 0, 0, 1);
      drive(0, 0, 4'd13, 1, 1, 4'd12, 1, 1, 1, 0, 2);
      drive(0, 0, 4'd12, 1, 1, 4'd14, 1, 0, 0, 0, 2);

      // 5: two consecutive errors drop lock, hunt/reseed, relock, step error
      drive(1, 0, 4'd0,  0, 0, 4'd0,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd0,  1, 0, 4'd2,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd2,  1, 0, 4'd4,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd4,  1, 1, 4'd6,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd7,  1, 1, 4'd8,  1, 1, 1, 0, 1);
      drive(0, 0, 4'd5,  1, 0, 4'd0,  0, 1, 1, 0, 2);
      drive(0, 0, 4'd3,  1, 0, 4'd0,  0, 0, 0, 0, 2);
      drive(0, 0, 4'd9,  0, 0, 4'd0,  0, 0, 0, 0, 2);
      drive(0, 0, 4'd8,  1, 0, 4'd10, 1, 0, 0, 0, 2);
      drive(0, 0, 4'd4,  1, 0, 4'd6,  1, 0, 0, 0, 2);
      drive(0, 0, 4'd6,  1, 0, 4'd8,  1, 0, 0, 0, 2);
      drive(0, 0, 4'd8,  1, 1, 4'd10, 1, 0, 0, 0, 2);
      drive(0, 0, 4'd2,  1, 1, 4'd12, 1, 1, 0, 1, 3);
      drive(0, 0, 4'd12, 1, 1, 4'd14, 1, 0, 0, 0, 3);

      // 6: mode toggle with a valid sample, odd lock, then saturate err_count
      drive(0, 1, 4'd14, 1, 0, 4'd0,  0, 0, 0, 0, 3);
      drive(0, 1, 4'd1,  1, 0, 4'd3,  1, 0, 0, 0, 3);
      drive(0, 1, 4'd3,  1, 0, 4'd5,  1, 0, 0, 0, 3);
      drive(0, 1, 4'd5,  1, 1, 4'd7,  1, 0, 0, 0, 3);
      for (int i = 0; i < 300; i++) begin
         e4  = 4'(7 + 4 * i);
         sat = (4 + i > 255) ? 8'd255 : 8'(4 + i);
         drive(0, 1, 4'd0,        1, 1, e4 + 4'd2, 1, 1, 1, 0, sat);
         drive(0, 1, e4 + 4'd2,   1, 1, e4 + 4'd4, 1, 0, 0, 0, sat);
      end
      drive(0, 1, 4'd2,  1, 1, 4'd9,  1, 1, 1, 0, 8'd255);
      drive(1, 0, 4'd3,  1, 0, 4'd0,  1, 0, 0, 0, 0);
      drive(0, 0, 4'd0,  0, 0, 4'd0,  1, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses left unchecked, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
